// File: rtl/result_broadcaster_pkg.sv
// ---------------------------------------------------------------------------
// ppc_types
//   Shared types and constants for the result/CDB path.
//   - PPC_RS_ID_WIDTH : system-wide reservation station tag width
//   - CDB_DATA_WIDTH  : width of a broadcast result value
//   - cdb_entry_t     : {rs_id, value} pair carried through the result FIFOs
//   - rr_index()      : modulo helper used by the round-robin search
// ---------------------------------------------------------------------------
package ppc_types;

  localparam int PPC_RS_ID_WIDTH = 5;
  localparam int CDB_DATA_WIDTH  = 32;

  typedef struct packed {
    logic [PPC_RS_ID_WIDTH-1:0] rs_id;
    logic [CDB_DATA_WIDTH-1:0]  value;
  } cdb_entry_t;

  // (base + offset) wrapped into 0..n-1; base and offset are always < n here.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/result_broadcaster_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Small per-unit result buffer holding cdb_entry_t items.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset (clears count/pointers)
//     i_push    : write i_data (ignored when full, even if popped same cycle)
//     i_data    : entry to write
//     i_pop     : remove head (ignored when empty)
//     o_full    : no free slot (decoded from registered count)
//     o_empty   : no valid entry (decoded from registered count)
//     o_head    : oldest entry, valid while !o_empty
// ---------------------------------------------------------------------------
module result_fifo
  import ppc_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  cdb_entry_t i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output cdb_entry_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Full blocks the push regardless of a simultaneous pop, so ready can be
  // a pure function of the registered count.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset: stale slots are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_broadcaster.sv
// ---------------------------------------------------------------------------
// result_broadcaster
//   Collects results from UNITS execution units into per-unit FIFOs and
//   broadcasts one result per cycle on the common data bus, chosen
//   round-robin among the non-empty FIFOs.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     result_valid[u] : unit u offers {result_rs_id[u], result_value[u]}
//     result_ready[u] : FIFO u has room (registered state only)
//     cdb_valid       : one-cycle pulse per broadcast
//     cdb_rs_id       : broadcast tag (holds when idle)
//     cdb_value       : broadcast value (holds when idle)
//   RS_ID_WIDTH is expected to equal ppc_types::PPC_RS_ID_WIDTH, since the
//   FIFO entries use the package struct.
// ---------------------------------------------------------------------------
module result_broadcaster
  import ppc_types::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = PPC_RS_ID_WIDTH,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   result_valid [0:UNITS-1],
  output logic                   result_ready [0:UNITS-1],
  input  logic [RS_ID_WIDTH-1:0] result_rs_id [0:UNITS-1],
  input  logic [31:0]            result_value [0:UNITS-1],
  output logic                   cdb_valid,
  output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  output logic [31:0]            cdb_value
);

  localparam int PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  cdb_entry_t       w_in    [UNITS];
  cdb_entry_t       w_head  [UNITS];
  logic             w_full  [UNITS];
  logic             w_empty [UNITS];
  logic             w_pop   [UNITS];

  logic             w_grant_valid;
  logic [PTR_W-1:0] w_grant_idx;
  cdb_entry_t       w_grant_entry;

  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_cdb_valid;
  logic [RS_ID_WIDTH-1:0] r_cdb_rs_id;
  logic [31:0]            r_cdb_value;

  genvar gi;
  generate
    for (gi = 0; gi < UNITS; gi++) begin : g_unit
      assign w_in[gi].rs_id   = result_rs_id[gi];
      assign w_in[gi].value   = result_value[gi];
      assign result_ready[gi] = !w_full[gi];
      assign w_pop[gi]        = w_grant_valid && (w_grant_idx == PTR_W'(gi));

      result_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (result_valid[gi]),
        .i_data  (w_in[gi]),
        .i_pop   (w_pop[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_head  (w_head[gi])
      );
    end
  endgenerate

  // Round-robin search: first non-empty FIFO at or after r_rr_ptr wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < UNITS; k++) begin
      if (!w_grant_valid && !w_empty[rr_index(int'(r_rr_ptr), k, UNITS)]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = PTR_W'(rr_index(int'(r_rr_ptr), k, UNITS));
      end
    end
  end

  assign w_grant_entry = w_head[w_grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_rs_id <= '0;
      r_cdb_value <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_cdb_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_cdb_rs_id <= w_grant_entry.rs_id;
        r_cdb_value <= w_grant_entry.value;
        // Pointer moves past the winner so it has lowest priority next time.
        r_rr_ptr    <= PTR_W'(rr_index(int'(w_grant_idx), 1, UNITS));
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_rs_id = r_cdb_rs_id;
  assign cdb_value = r_cdb_value;

endmodule

// File: tb/tb_result_broadcaster.sv
// ---------------------------------------------------------------------------
// tb_result_broadcaster
//   Scoreboard bench: every accepted result is pushed into a per-unit
//   expected queue; every CDB broadcast is compared against the head of the
//   queue the round-robin rule selects.
// ---------------------------------------------------------------------------
module tb_result_broadcaster;
  import ppc_types::*;

  localparam int UNITS = 4;
  localparam int RSW   = 5;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           result_valid [0:UNITS-1];
  logic           result_ready [0:UNITS-1];
  logic [RSW-1:0] result_rs_id [0:UNITS-1];
  logic [31:0]    result_value [0:UNITS-1];
  logic           cdb_valid;
  logic [RSW-1:0] cdb_rs_id;
  logic [31:0]    cdb_value;

  always #5 clk = ~clk;

  result_broadcaster #(
    .UNITS       (UNITS),
    .RS_ID_WIDTH (RSW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_rs_id (result_rs_id),
    .result_value (result_value),
    .cdb_valid    (cdb_valid),
    .cdb_rs_id    (cdb_rs_id),
    .cdb_value    (cdb_value)
  );

  int n_checks = 0;
  int n_fail   = 0;

  cdb_entry_t     src [UNITS][$];   // items waiting to be offered per unit
  cdb_entry_t     q   [UNITS][$];   // expected (accepted, not yet broadcast)
  int             log_unit [$];
  logic [RSW-1:0] log_rs   [$];

  logic       acc_pend [UNITS];
  cdb_entry_t acc_item [UNITS];
  int         rr_model   = 0;
  bit         rand_mode  = 1'b0;
  bit         saw_full0  = 1'b0;
  int         n_accepted = 0;
  int         mon_exp_u;
  int         serial     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic cdb_entry_t mk(input int rs, input logic [31:0] val);
    cdb_entry_t e;
    e.rs_id = RSW'(rs);
    e.value = val;
    return e;
  endfunction

  function automatic int log_rs_at(input int i);
    if (i < log_rs.size()) return int'(log_rs[i]);
    return -1;
  endfunction

  function automatic int pending_total();
    int t = 0;
    for (int u = 0; u < UNITS; u++) t += src[u].size() + q[u].size();
    return t;
  endfunction

  // Driver: offers the head of each source queue at the falling edge and
  // notes whether the DUT will accept it at the next rising edge.
  initial begin
    for (int u = 0; u < UNITS; u++) begin
      result_valid[u] = 1'b0;
      result_rs_id[u] = '0;
      result_value[u] = '0;
      acc_pend[u]     = 1'b0;
      acc_item[u]     = '0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < UNITS; u++) begin
        if (!rst && src[u].size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
          result_valid[u] = 1'b1;
          result_rs_id[u] = src[u][0].rs_id;
          result_value[u] = src[u][0].value;
        end else begin
          result_valid[u] = 1'b0;
        end
      end
      #1;
      for (int u = 0; u < UNITS; u++) begin
        acc_pend[u] = !rst && result_valid[u] && result_ready[u];
        acc_item[u] = mk(int'(result_rs_id[u]), result_value[u]);
      end
    end
  end

  // Monitor / scoreboard, evaluated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int u = 0; u < UNITS; u++) acc_pend[u] = 1'b0;
      end else begin
        mon_exp_u = -1;
        for (int k = 0; k < UNITS; k++) begin
          if (mon_exp_u < 0 && q[(rr_model + k) % UNITS].size() > 0)
            mon_exp_u = (rr_model + k) % UNITS;
        end
        check_eq("cdb_valid", 64'(cdb_valid), 64'(mon_exp_u >= 0));
        if (cdb_valid && mon_exp_u >= 0) begin
          check_eq("cdb_entry", 64'({cdb_rs_id, cdb_value}), 64'(q[mon_exp_u][0]));
          log_unit.push_back(mon_exp_u);
          log_rs.push_back(cdb_rs_id);
          void'(q[mon_exp_u].pop_front());
          rr_model = (mon_exp_u + 1) % UNITS;
        end
        for (int u = 0; u < UNITS; u++) begin
          if (acc_pend[u]) begin
            q[u].push_back(acc_item[u]);
            if (src[u].size() > 0) void'(src[u].pop_front());
            n_accepted++;
            acc_pend[u] = 1'b0;
          end
        end
        for (int u = 0; u < UNITS; u++)
          check_eq("result_ready", 64'(result_ready[u]), 64'(q[u].size() < DEPTH));
        if (!result_ready[0]) saw_full0 = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    rand_mode = 1'b0;
    for (int u = 0; u < UNITS; u++) begin
      src[u].delete();
      q[u].delete();
    end
    rr_model = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int u0_seen;
  int drain_wait;

  initial begin
    // Reset state while reset is held from time zero.
    #1;
    check_eq("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_cdb_rs_id", 64'(cdb_rs_id), 64'd0);
    check_eq("rst_cdb_value", 64'(cdb_value), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int u = 0; u < UNITS; u++)
      check_eq("rst_ready", 64'(result_ready[u]), 64'd1);

    // Single result from unit 2, two-cycle latency, one-cycle pulse.
    do_reset();
    src[2].push_back(mk(5, 32'hDEADBEEF));
    @(posedge clk); #2;
    check_eq("single_edge0_valid", 64'(cdb_valid), 64'd0);
    @(posedge clk); #2;
    check_eq("single_valid", 64'(cdb_valid), 64'd1);
    check_eq("single_rs_id", 64'(cdb_rs_id), 64'd5);
    check_eq("single_value", 64'(cdb_value), 64'hDEADBEEF);
    @(posedge clk); #2;
    check_eq("single_pulse_end", 64'(cdb_valid), 64'd0);
    check_eq("single_hold_rs_id", 64'(cdb_rs_id), 64'd5);

    // All four units push at once: order 1,2,3,4; pointer back to 0.
    do_reset();
    log_unit.delete(); log_rs.delete();
    for (int u = 0; u < UNITS; u++) src[u].push_back(mk(u + 1, 32'h1000 + u));
    repeat (8) @(posedge clk); #2;
    src[1].push_back(mk(6, 32'h2001));
    src[3].push_back(mk(7, 32'h2003));
    repeat (6) @(posedge clk); #2;
    check_eq("simul_count", 64'(log_rs.size()), 64'd6);
    for (int i = 0; i < 4; i++) check_eq("simul_order", 64'(log_rs_at(i)), 64'(i + 1));
    check_eq("rr_wrap_first", 64'(log_rs_at(4)), 64'd6);
    check_eq("rr_wrap_second", 64'(log_rs_at(5)), 64'd7);

    // Unit 0 fills while unit 1 competes; nothing lost, order kept.
    do_reset();
    log_unit.delete(); log_rs.delete();
    saw_full0 = 1'b0;
    for (int i = 0; i < 3; i++) src[0].push_back(mk(10 + i, 32'hA000 + i));
    for (int i = 0; i < 6; i++) src[1].push_back(mk(13 + i, 32'hB000 + i));
    repeat (20) @(posedge clk); #2;
    check_eq("fill_full_seen", 64'(saw_full0), 64'd1);
    check_eq("fill_total", 64'(log_rs.size()), 64'd9);
    u0_seen = 0;
    for (int i = 0; i < log_rs.size(); i++) begin
      if (log_unit[i] == 0) begin
        check_eq("fill_u0_order", 64'(log_rs[i]), 64'(10 + u0_seen));
        u0_seen++;
      end
    end
    check_eq("fill_u0_count", 64'(u0_seen), 64'd3);

    // Fairness between units 0 and 3.
    do_reset();
    log_unit.delete(); log_rs.delete();
    for (int i = 0; i < 8; i++) begin
      src[0].push_back(mk(i, 32'h0000_0100 + i));
      src[3].push_back(mk(24 + i, 32'h3000_0100 + i));
    end
    repeat (24) @(posedge clk); #2;
    check_eq("fair_count", 64'(log_unit.size()), 64'd16);
    for (int i = 0; i < 16 && i < log_unit.size(); i++)
      check_eq("fair_alternate", 64'(log_unit[i]), 64'((i % 2 == 0) ? 0 : 3));

    // Asynchronous reset with entries still pending.
    do_reset();
    src[0].push_back(mk(19, 32'h1919));
    src[1].push_back(mk(20, 32'h2020));
    src[2].push_back(mk(21, 32'h2121));
    @(posedge clk);
    @(posedge clk);
    #3;
    check_eq("midrst_pre_valid", 64'(cdb_valid), 64'd1);
    rst = 1'b1;
    for (int u = 0; u < UNITS; u++) begin
      src[u].delete();
      q[u].delete();
    end
    rr_model = 0;
    #1;
    check_eq("midrst_valid", 64'(cdb_valid), 64'd0);
    check_eq("midrst_rs_id", 64'(cdb_rs_id), 64'd0);
    check_eq("midrst_value", 64'(cdb_value), 64'd0);
    for (int u = 0; u < UNITS; u++)
      check_eq("midrst_ready", 64'(result_ready[u]), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    log_unit.delete(); log_rs.delete();
    repeat (10) @(posedge clk); #2;
    check_eq("midrst_no_bcast", 64'(log_rs.size()), 64'd0);

    // Random stress.
    do_reset();
    log_unit.delete(); log_rs.delete();
    n_accepted = 0;
    rand_mode  = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #3;
      for (int u = 0; u < UNITS; u++) begin
        if (src[u].size() < 2 && $urandom_range(0, 3) != 0) begin
          src[u].push_back(mk(int'($urandom_range(0, 31)), 32'(serial)));
          serial++;
        end
      end
    end
    rand_mode  = 1'b0;
    drain_wait = 0;
    while (pending_total() > 0 && drain_wait < 200) begin
      @(posedge clk); #3;
      drain_wait++;
    end
    check_eq("stress_drained", 64'(pending_total()), 64'd0);
    check_eq("stress_bcast_count", 64'(log_rs.size()), 64'(n_accepted));
    check_eq("stress_activity", 64'(n_accepted > 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_broadcaster.md
RESULT_BROADCASTER -- requirements
Module: result_broadcaster

Interface
REQ-001 SHALL have parameter UNITS, default 4: number of execution units producing results.
REQ-002 SHALL have parameter RS_ID_WIDTH, default 5: width of the reservation station ID carried with each result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: number of entries in each unit's result buffer, at least 1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  system clock, rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have result_valid[0:UNITS-1]  in  1 each  unit result valid.
REQ-007 SHALL have result_ready[0:UNITS-1]  out  1 each  unit result accepted.
REQ-008 SHALL have result_rs_id[0:UNITS-1]  in  RS_ID_WIDTH each  ID of the reservation station that produced the result.
REQ-009 SHALL have result_value[0:UNITS-1]  in  32 each  result value.
REQ-010 SHALL have cdb_valid  out  1  broadcast valid, driven to the operand_valid inputs of every reservation station.
REQ-011 SHALL have cdb_rs_id  out  RS_ID_WIDTH  broadcast tag.
REQ-012 SHALL have cdb_value  out  32  broadcast value.

Function
REQ-013 SHALL hold one FIFO of FIFO_DEPTH {rs_id, value} entries per unit.
REQ-014 SHALL drive result_ready[u] = FIFO u not full, from registered state only, with no combinational path from result_valid.
REQ-015 SHALL push the entry into FIFO u on a rising edge where result_valid[u] && result_ready[u]; a full FIFO SHALL NOT accept a push, even in a cycle where it is also popped.
REQ-016 SHALL, each cycle, grant exactly one non-empty FIFO, searched round-robin starting at rr_ptr (width clog2(UNITS), wrapping from UNITS-1 to 0).
REQ-017 SHALL, on a grant to unit w, pop FIFO w, register its head into cdb_rs_id/cdb_value, set cdb_valid=1, and set rr_ptr <= (w+1) mod UNITS.
REQ-018 SHALL, when all FIFOs are empty, set cdb_valid=0 with cdb_rs_id/cdb_value holding their values and rr_ptr unchanged.
REQ-019 SHALL register all outputs; cdb_valid SHALL pulse for exactly one cycle per broadcast, with no backpressure from the CDB.
REQ-020 SHALL give a minimum latency of 2 cycles: a result accepted at edge N appears on the CDB during the cycle following edge N+1.
REQ-021 SHALL preserve per-unit order; ordering between units is set only by round-robin.
REQ-022 SHALL broadcast each accepted entry exactly once: none dropped, none duplicated.
REQ-023 SHALL bound starvation: a non-empty FIFO is granted within UNITS cycles.
REQ-024 SHALL allow push and pop of the same non-full FIFO in one cycle; occupancy is then unchanged.
REQ-025 SHALL allow all UNITS to push in the same cycle; sustained CDB throughput is one result per cycle.

Reset
REQ-026 SHALL, on rst asserting at any time (including mid-transfer), immediately clear: cdb_valid=0, cdb_rs_id=0, cdb_value=0, rr_ptr=0, all FIFO counts/pointers=0.
REQ-027 SHALL drive result_ready all 1 after reset; entries pending at reset SHALL be discarded and never broadcast.

Structure
REQ-028 SHALL define typedef cdb_entry_t {rs_id, value} in package ppc_types; RS_ID_WIDTH for it SHALL come from the system-wide constant in that package.
REQ-029 SHALL instantiate sub-module result_fifo (depth FIFO_DEPTH, async reset, push/pop/full/empty/head) UNITS times.
REQ-030 SHALL keep the round-robin arbiter and CDB output registers in result_broadcaster.

Verification
REQ-031 Single result: unit 2 pushes rs_id=5, value=0xDEADBEEF at edge 0 -> cdb_valid=1, rs_id=5, value=0xDEADBEEF for exactly one cycle after edge 1, then cdb_valid=0.
REQ-032 Simultaneous push, all 4 units at one edge, rs_ids 1,2,3,4, rr_ptr=0 -> broadcasts in order 1,2,3,4 on consecutive cycles; rr_ptr ends at 0.
REQ-033 Fill FIFO: unit 0 holds result_valid high for 3 cycles while unit 1 keeps winning arbitration -> result_ready[0]=0 once count=2; no push while full; all 3 values broadcast in order, none lost.
REQ-034 Fairness: units 0 and 3 both continuously valid -> grants alternate 0,3,0,3 with no gap longer than UNITS cycles.
REQ-035 Reset mid-operation: rst asserted asynchronously with 2 entries pending -> outputs are 0 immediately, result_ready all 1, and the pending rs_ids never appear on the CDB after reset releases.
REQ-036 Random stress: 10k cycles of random valid on all units -> scoreboard matches the multiset of broadcasts, per-unit order holds, and cdb_valid=1 in every cycle where any FIFO is non-empty.
